uart_link: RTL and testbench
============================

# uart_link

Full-duplex 8N1 UART byte link between the board serial pins and the host-protocol command handler. The receive side deserialises host bytes and presents each one with a level ready flag. The transmit side serialises one response byte per request and reports a busy flag that the command handler uses as its send acknowledge. Baud timing comes from a single integer divider derived from parameters.

## Interface

Parameters:
- CLK_FREQ, 27000000: system clock frequency in Hz.
- BAUD, 115200: line rate. CLKS_PER_BIT = CLK_FREQ / BAUD, integer division; must be ≥ 4.

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1: system clock; all logic on rising edge.
- rst, in, 1: asynchronous active-high reset.
- uartRx, in, 1: serial line from host; idle high; asynchronous to clk.
- uartTx, out, 1: serial line to host; idle high.
- rxData, out, 8: last correctly framed received byte.
- rxByteReady, out, 1: level flag; high while rxData holds a fresh byte.
- rxFrameErr, out, 1: one-cycle pulse when the stop bit is sampled low.
- txStart, in, 1: level request to send txData; sampled only while TX is idle.
- txData, in, 8: byte to send; latched on the accepting cycle.
- txSending, out, 1: high for the whole frame, from the accept cycle to the end of the stop bit.

## Operation

- RX input path: 2-flop synchroniser, both flops reset to 1. All RX logic uses the second flop (rxs).
- RX states:
  - R_IDLE: a falling edge on rxs moves to R_START and loads bit counter = CLKS_PER_BIT/2 − 1.
  - R_START: at counter 0, sample rxs at mid start bit.
    - rxs = 1 is a false start: return to R_IDLE with no flags.
    - rxs = 0: go to R_DATA with bit index 0 and counter CLKS_PER_BIT − 1.
  - R_DATA: at each counter 0, shift rxs into the shift register, LSB first. After bit 7, go to R_STOP.
  - R_STOP: at counter 0, sample the stop bit.
    - rxs = 1: rxData ← shift register, rxByteReady ← 1.
    - rxs = 0: rxFrameErr pulses 1 cycle; rxData and rxByteReady are unchanged.
    - Either way, return to R_IDLE on the same edge, which allows back-to-back frames.
- rxByteReady clears on the cycle R_IDLE detects the next start edge. Nothing else clears it except reset.
- TX states:
  - T_IDLE: when txStart = 1, latch txData, set txSending = 1, and go to T_START.
  - T_START: uartTx = 0.
  - T_DATA: uartTx = current bit, LSB first, 8 bits.
  - T_STOP: uartTx = 1.
  - Each of T_START, T_DATA bits and T_STOP lasts exactly CLKS_PER_BIT cycles.
- End of T_STOP: go to T_IDLE and clear txSending. T_IDLE spends at least 1 cycle before accepting again.
- txStart still high after a frame completes: a new frame starts, with txData re-latched.
- Changes to txData or txStart mid-frame have no effect.
- RX and TX are fully independent and may run simultaneously.

## Timing

- Reset values:
  - uartTx = 1; txSending = 0; rxByteReady = 0; rxData = 0x00; rxFrameErr = 0.
  - Both FSMs idle; counters 0; synchroniser flops 1.
- Reset mid-frame: outputs return to reset values asynchronously; any partial byte is discarded.
- TX timing:
  - Accept cycle is edge N; uartTx goes low and txSending goes high as registered outputs after edge N.
  - Frame length is 10·CLKS_PER_BIT cycles; txSending falls exactly 10·CLKS_PER_BIT cycles after it rose.
- RX latency:
  - From the uartRx falling edge to the start-edge detect: 2 clk of synchroniser plus 1.
  - From start-edge detect to rxByteReady high: CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles.
- Sampling point: mid-bit (±1 clk). This tolerates ±4% baud mismatch with CLKS_PER_BIT ≥ 16.
- Counter width: clog2(CLKS_PER_BIT). The counter counts down and reloads at 0; it never wraps through the maximum value.

## Test plan

Bench uses CLK_FREQ = 1000000 and BAUD = 100000, so CLKS_PER_BIT = 10.

- RX 0x70 ("p"): drive a frame on uartRx → rxData = 0x70; rxByteReady rises 97–99 cycles after the falling edge; rxFrameErr stays 0. The next start edge clears rxByteReady.
- TX 0x50: hold txStart for 1 cycle with txData = 0x50 → uartTx emits 0,0,0,0,0,1,0,1,0,1, each level for exactly 10 cycles; txSending high for exactly 100 cycles.
- Framing error: RX frame 0xA5 with stop bit 0 → one 1-cycle rxFrameErr pulse; rxByteReady stays 0; rxData keeps its previous value.
- Glitch: 3-cycle low pulse on an idle uartRx → false start; no rxByteReady, no rxFrameErr; RX returns to idle.
- Loopback, back-to-back: uartTx tied to uartRx; txStart held high with txData = 0x57, then changed to 0xA5 during frame 1 →
  - RX receives 0x57, then 0xA5.
  - txSending low for exactly 1 cycle between frames.
- Reset mid-TX: assert rst during data bit 3 → uartTx = 1 and txSending = 0 immediately. After release, a new txStart sends a clean full frame.

Source files
------------

// File: rtl/uart_link.sv
// uart_link: full-duplex 8N1 UART byte link with a single integer baud divider.
// RX samples a synchronised line mid-bit; TX serialises one byte per accept.
module uart_link #(
   parameter int CLK_FREQ = 27000000,
   parameter int BAUD     = 115200
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uartRx,
   output logic       uartTx,
   output logic [7:0] rxData,
   output logic       rxByteReady,
   output logic       rxFrameErr,
   input  logic       txStart,
   input  logic [7:0] txData,
   output logic       txSending
);
   localparam int CPB = CLK_FREQ / BAUD;
   localparam int CW  = $clog2(CPB);
   localparam logic [CW-1:0] HALF_M1 = CW'(CPB / 2 - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(CPB - 1);
   localparam logic [CW-1:0] ONE     = CW'(1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
   typedef enum logic [1:0] {T_IDLE, T_START, T_DATA, T_STOP} tx_state_e;

   logic          rx_meta_q, rxs_q, rxs_prev_q;
   rx_state_e     rx_st_q, rx_st_d;
   logic [CW-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]    rx_idx_q, rx_idx_d;
   logic [7:0]    rx_sh_q, rx_sh_d;
   logic [7:0]    rx_data_q, rx_data_d;
   logic          rx_rdy_q, rx_rdy_d;
   logic          rx_err_q, rx_err_d;

   tx_state_e     tx_st_q, tx_st_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_idx_q, tx_idx_d;
   logic [7:0]    tx_sh_q, tx_sh_d;
   logic          tx_line_q, tx_line_d;
   logic          tx_busy_q, tx_busy_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         rx_st_q    <= R_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_sh_q    <= '0;
         rx_data_q  <= '0;
         rx_rdy_q   <= 1'b0;
         rx_err_q   <= 1'b0;
      end else begin
         rx_meta_q  <= uartRx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
         rx_st_q    <= rx_st_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_sh_q    <= rx_sh_d;
         rx_data_q  <= rx_data_d;
         rx_rdy_q   <= rx_rdy_d;
         rx_err_q   <= rx_err_d;
      end
   end

   always_comb begin
      rx_st_d   = rx_st_q;
      rx_cnt_d  = rx_cnt_q;
      rx_idx_d  = rx_idx_q;
      rx_sh_d   = rx_sh_q;
      rx_data_d = rx_data_q;
      rx_rdy_d  = rx_rdy_q;
      rx_err_d  = 1'b0;
      unique case (rx_st_q)
         R_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               rx_st_d  = R_START;
               rx_cnt_d = HALF_M1;
               rx_rdy_d = 1'b0;
            end
         end
         R_START: begin
            if (rx_cnt_q != '0) begin
               rx_cnt_d = rx_cnt_q - ONE;
            end else if (rxs_q) begin
               rx_st_d = R_IDLE;
            end else begin
               rx_st_d  = R_DATA;
               rx_idx_d = '0;
               rx_cnt_d = FULL_M1;
            end
         end
         R_DATA: begin
            if (rx_cnt_q != '0) begin
               rx_cnt_d = rx_cnt_q - ONE;
            end else begin
               rx_sh_d  = {rxs_q, rx_sh_q[7:1]};
               rx_cnt_d = FULL_M1;
               if (rx_idx_q == 3'd7) rx_st_d = R_STOP;
               else rx_idx_d = rx_idx_q + 3'd1;
            end
         end
         R_STOP: begin
            if (rx_cnt_q != '0) begin
               rx_cnt_d = rx_cnt_q - ONE;
            end else begin
               // back to idle on the sampling edge so a following frame is not missed
               rx_st_d = R_IDLE;
               if (rxs_q) begin
                  rx_data_d = rx_sh_q;
                  rx_rdy_d  = 1'b1;
               end else begin
                  rx_err_d = 1'b1;
               end
            end
         end
         default: rx_st_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_st_q   <= T_IDLE;
         tx_cnt_q  <= '0;
         tx_idx_q  <= '0;
         tx_sh_q   <= '0;
         tx_line_q <= 1'b1;
         tx_busy_q <= 1'b0;
      end else begin
         tx_st_q   <= tx_st_d;
         tx_cnt_q  <= tx_cnt_d;
         tx_idx_q  <= tx_idx_d;
         tx_sh_q   <= tx_sh_d;
         tx_line_q <= tx_line_d;
         tx_busy_q <= tx_busy_d;
      end
   end

   always_comb begin
      tx_st_d   = tx_st_q;
      tx_cnt_d  = tx_cnt_q;
      tx_idx_d  = tx_idx_q;
      tx_sh_d   = tx_sh_q;
      tx_line_d = tx_line_q;
      tx_busy_d = tx_busy_q;
      unique case (tx_st_q)
         T_IDLE: begin
            if (txStart) begin
               tx_st_d   = T_START;
               tx_sh_d   = txData;
               tx_idx_d  = '0;
               tx_cnt_d  = FULL_M1;
               tx_line_d = 1'b0;
               tx_busy_d = 1'b1;
            end
         end
         T_START: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - ONE;
            end else begin
               tx_st_d   = T_DATA;
               tx_cnt_d  = FULL_M1;
               tx_line_d = tx_sh_q[0];
            end
         end
         T_DATA: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - ONE;
            end else begin
               tx_cnt_d = FULL_M1;
               if (tx_idx_q == 3'd7) begin
                  tx_st_d   = T_STOP;
                  tx_line_d = 1'b1;
               end else begin
                  tx_idx_d  = tx_idx_q + 3'd1;
                  tx_sh_d   = {1'b0, tx_sh_q[7:1]};
                  tx_line_d = tx_sh_q[1];
               end
            end
         end
         T_STOP: begin
            if (tx_cnt_q != '0) begin
               tx_cnt_d = tx_cnt_q - ONE;
            end else begin
               tx_st_d   = T_IDLE;
               tx_busy_d = 1'b0;
            end
         end
         default: tx_st_d = T_IDLE;
      endcase
   end

   assign uartTx      = tx_line_q;
   assign txSending   = tx_busy_q;
   assign rxData      = rx_data_q;
   assign rxByteReady = rx_rdy_q;
   assign rxFrameErr  = rx_err_q;
endmodule

// File: tb/tb_uart_link.sv
// tb_uart_link: randomized scoreboard bench for uart_link.
// Expected bytes/frames are queued at stimulus time and popped by line monitors.
module tb_uart_link;
   localparam int CPB = 10;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx_drv = 1'b1;
   logic       loop_en = 1'b0;
   logic       uartRx, uartTx;
   logic [7:0] rxData;
   logic       rxByteReady, rxFrameErr;
   logic       txStart = 1'b0;
   logic [7:0] txData = 8'h00;
   logic       txSending;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [7:0] rx_exp[$];
   logic [7:0] tx_exp[$];
   int err_exp = 0;
   logic [7:0] last_good = 8'h00;
   int fall_cyc = 0;
   bit chk_lat = 1'b0;
   bit chk_gap = 1'b0;

   assign uartRx = loop_en ? uartTx : rx_drv;

   uart_link #(.CLK_FREQ(1000000), .BAUD(100000)) dut (
      .clk(clk), .rst(rst), .uartRx(uartRx), .uartTx(uartTx),
      .rxData(rxData), .rxByteReady(rxByteReady), .rxFrameErr(rxFrameErr),
      .txStart(txStart), .txData(txData), .txSending(txSending)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // RX-side monitor: compares every new ready byte and every error pulse
   initial begin : rx_mon
      logic prev_rdy;
      logic [7:0] e;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_rdy = 1'b0;
            continue;
         end
         if (rxByteReady && !prev_rdy) begin
            chk("rx_byte_expected", rx_exp.size() > 0, 1);
            if (rx_exp.size() > 0) begin
               e = rx_exp.pop_front();
               chk("rx_data", rxData, e);
               last_good = e;
            end
            if (chk_lat) begin
               chk("rx_latency_97_99",
                   (cyc - fall_cyc >= 97) && (cyc - fall_cyc <= 99), 1);
               chk_lat = 1'b0;
            end
         end
         if (rxFrameErr) begin
            chk("rx_err_expected", err_exp > 0, 1);
            if (err_exp > 0) err_exp--;
         end
         prev_rdy = rxByteReady;
      end
   end

   // TX-side monitor: checks every bit period and the busy window of each frame
   initial begin : tx_mon
      logic prev_s;
      logic [9:0] fr;
      logic [7:0] b;
      bit ok, ab;
      int last_fall;
      prev_s = 1'b0;
      last_fall = -1000;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_s = 1'b0;
            continue;
         end
         if (txSending && !prev_s) begin
            if (chk_gap) begin
               chk("tx_gap_cycles", cyc - last_fall, 1);
               chk_gap = 1'b0;
            end
            chk("tx_frame_expected", tx_exp.size() > 0, 1);
            b = 8'h00;
            if (tx_exp.size() > 0) b = tx_exp.pop_front();
            fr = {1'b1, b, 1'b0};
            ok = 1'b1;
            ab = 1'b0;
            for (int c = 0; c < 10 * CPB; c++) begin
               if (rst) begin
                  ab = 1'b1;
                  break;
               end
               if (uartTx !== fr[c / CPB] || txSending !== 1'b1) ok = 1'b0;
               @(negedge clk);
            end
            if (ab) begin
               prev_s = 1'b0;
               continue;
            end
            chk("tx_frame_bits", ok, 1);
            chk("tx_sending_len", txSending, 0);
            last_fall = cyc;
         end
         prev_s = txSending;
      end
   end

   task automatic rx_bit(logic v);
      rx_drv = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_rx(logic [7:0] b, logic stop);
      @(negedge clk);
      fall_cyc = cyc;
      rx_bit(1'b0);
      for (int i = 0; i < 8; i++) rx_bit(b[i]);
      rx_bit(stop);
      rx_drv = 1'b1;
      if (!stop) repeat (CPB) @(negedge clk);
   endtask

   task automatic wait_sending(logic lvl, string nm);
      int n;
      n = 0;
      while (txSending !== lvl && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (txSending !== lvl) chk(nm, txSending, lvl);
   endtask

   task automatic send_tx(logic [7:0] b);
      tx_exp.push_back(b);
      @(negedge clk);
      txData = b;
      txStart = 1'b1;
      wait_sending(1'b1, "tx_accept_timeout");
      txStart = 1'b0;
      txData = 8'($urandom);
      wait_sending(1'b0, "tx_end_timeout");
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [7:0] a, b;
      logic stop;
      repeat (3) @(negedge clk);
      chk("rst_uartTx", uartTx, 1);
      chk("rst_txSending", txSending, 0);
      chk("rst_rxByteReady", rxByteReady, 0);
      chk("rst_rxData", rxData, 0);
      chk("rst_rxFrameErr", rxFrameErr, 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      rx_exp.push_back(8'h70);
      chk_lat = 1'b1;
      send_rx(8'h70, 1'b1);
      repeat (3) @(negedge clk);
      chk("rx_ready_held", rxByteReady, 1);
      b = 8'($urandom);
      rx_exp.push_back(b);
      fork
         send_rx(b, 1'b1);
         begin
            repeat (6) @(negedge clk);
            chk("rx_ready_cleared", rxByteReady, 0);
         end
      join
      repeat (5) @(negedge clk);

      send_tx(8'h50);
      repeat (5) @(negedge clk);

      err_exp++;
      send_rx(8'hA5, 1'b0);
      repeat (5) @(negedge clk);
      chk("ferr_no_ready", rxByteReady, 0);
      chk("ferr_data_kept", rxData, last_good);

      @(negedge clk);
      rx_drv = 1'b0;
      repeat (3) @(negedge clk);
      rx_drv = 1'b1;
      repeat (20) @(negedge clk);
      chk("glitch_no_ready", rxByteReady, 0);
      b = 8'($urandom);
      rx_exp.push_back(b);
      send_rx(b, 1'b1);
      repeat (5) @(negedge clk);

      for (int k = 0; k < 8; k++) begin
         a = 8'($urandom);
         b = 8'($urandom);
         stop = ($urandom_range(0, 3) != 0);
         if (stop) rx_exp.push_back(a);
         else err_exp++;
         fork
            send_rx(a, stop);
            send_tx(b);
         join
         repeat ($urandom_range(1, 8)) @(negedge clk);
      end

      @(negedge clk);
      loop_en = 1'b1;
      tx_exp.push_back(8'h57);
      rx_exp.push_back(8'h57);
      txData = 8'h57;
      txStart = 1'b1;
      wait_sending(1'b1, "lb_accept_timeout");
      chk_gap = 1'b1;
      repeat (30) @(negedge clk);
      txData = 8'hA5;
      tx_exp.push_back(8'hA5);
      rx_exp.push_back(8'hA5);
      wait_sending(1'b0, "lb_gap_timeout");
      wait_sending(1'b1, "lb_second_timeout");
      txStart = 1'b0;
      wait_sending(1'b0, "lb_end_timeout");
      repeat (20) @(negedge clk);
      chk("lb_last_byte", rxData, 8'hA5);
      loop_en = 1'b0;
      repeat (5) @(negedge clk);

      tx_exp.push_back(8'h3C);
      txData = 8'h3C;
      txStart = 1'b1;
      wait_sending(1'b1, "rst_tx_accept_timeout");
      txStart = 1'b0;
      repeat (44) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midrst_uartTx", uartTx, 1);
      chk("midrst_txSending", txSending, 0);
      chk("midrst_rxData", rxData, 0);
      @(negedge clk);
      rst = 1'b0;
      tx_exp.delete();
      last_good = 8'h00;
      repeat (3) @(negedge clk);
      send_tx(8'($urandom));

      repeat (30) @(negedge clk);
      chk("end_rx_queue", rx_exp.size(), 0);
      chk("end_tx_queue", tx_exp.size(), 0);
      chk("end_err_count", err_exp, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
